// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline.
// It produces stall/flush for IF/ID and ID/EX, and forwarding selects for the
// D- and E-stage operand muxes. It also tracks the multi-cycle mult/div unit
// and counts stalled cycles.
// Handshake note: there is no valid/ready pair here. Every stall is a level
// that holds the front end in the same cycle it is raised, and every flush
// is a level that clears the register at the next edge.
module pipeline_hazard_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic [4:0]       WriteRegM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemToRegE,
  input  logic             MemToRegM,
  input  logic             BranchD,
  input  logic             JumpD,
  input  logic             PCSrcD,
  input  logic             MdStartD,
  input  logic             HiLoReadD,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MdBusy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             md_state      // debug view of the mult/div FSM, 1 = BUSY
);

  localparam int MDC_W = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
  localparam logic [MDC_W-1:0] MD_LOAD = MDC_W'(MD_LATENCY - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_t;

  md_state_t        state, state_nxt;
  logic [MDC_W-1:0] md_cnt, md_cnt_nxt;

  logic lwstall, brstall, mdstall, stall;
  logic m_hit_rsd, m_hit_rtd, e_hit_rsd, e_hit_rtd;

  // Register-match terms; $0 is hard-wired zero and never creates a hazard.
  always_comb begin
    m_hit_rsd = (RsD != 5'd0) && (WriteRegM == RsD);
    m_hit_rtd = (RtD != 5'd0) && (WriteRegM == RtD);
    e_hit_rsd = (RsD != 5'd0) && (WriteRegE == RsD);
    e_hit_rtd = (RtD != 5'd0) && (WriteRegE == RtD);
  end

  // Hazard detection: load-use, branch-in-ID operand not ready, mult/div busy.
  always_comb begin
    lwstall = MemToRegE && (e_hit_rsd || e_hit_rtd);
    brstall = BranchD && ((RegWriteE && (e_hit_rsd || e_hit_rtd)) ||
                          (MemToRegM && (m_hit_rsd || m_hit_rtd)));
    mdstall = MdBusy && (MdStartD || HiLoReadD);
    stall   = lwstall || brstall || mdstall;
  end

  // Stall/flush and forwarding outputs; reset forces a clean, flushed pipe.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushE    = 1'b1;
    FlushD    = 1'b1;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (!reset) begin
      StallF    = stall;
      StallD    = stall;
      FlushE    = stall;
      // A stalled branch has not been resolved yet, so it must not flush.
      FlushD    = ((PCSrcD && BranchD) || JumpD) && !stall;
      ForwardAD = RegWriteM && m_hit_rsd;
      ForwardBD = RegWriteM && m_hit_rtd;
      // MEM result is newer than WB, so it takes priority.
      if (RegWriteM && (RsE != 5'd0) && (WriteRegM == RsE))      ForwardAE = 2'b10;
      else if (RegWriteW && (RsE != 5'd0) && (WriteRegW == RsE)) ForwardAE = 2'b01;
      if (RegWriteM && (RtE != 5'd0) && (WriteRegM == RtE))      ForwardBE = 2'b10;
      else if (RegWriteW && (RtE != 5'd0) && (WriteRegW == RtE)) ForwardBE = 2'b01;
    end
  end

  // Mult/div next state: issue only when the issuing instruction advances.
  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    case (state)
      IDLE: begin
        if (MdStartD && !stall) begin
          state_nxt  = BUSY;
          md_cnt_nxt = MD_LOAD;
        end
      end
      BUSY: begin
        if (md_cnt == '0) state_nxt  = IDLE;
        else              md_cnt_nxt = md_cnt - 1'b1;
      end
      default: begin
        state_nxt  = IDLE;
        md_cnt_nxt = '0;
      end
    endcase
  end

  // Mult/div state register; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      md_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  // Performance counter of stalled cycles, wraps naturally.
  always_ff @(posedge clk) begin
    if (reset)      stall_cycles <= '0;
    else if (stall) stall_cycles <= stall_cycles + 1'b1;
  end

  assign MdBusy   = (state == BUSY);
  assign md_state = state;

endmodule
